nou_spu_rd_master: RTL and testbench
====================================

Name: nou_spu_rd_master

Overview:
- Send-side counterpart of the NOU receive path: the receive path drains data flits into memory over AXI write; this block fetches a packet from memory over AXI read and emits it as data flits on the outbound data channel to the router.
- It reads the header region first, then the data region, splitting each region into AXI INCR bursts.
- Driven by the send-packet controller via a start/done handshake.

Parameters:
- DATA_WIDTH, 512, AXI R data width and flit width (bits); bytes per beat BPB = DATA_WIDTH/8.
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 4, AXI ARID width.
- SZ_WIDTH, 16, byte-size field width for header/data lengths.
- MAX_BURST, 16, maximum beats per AR burst (1..256).
- ARID_VAL, 0, constant ARID driven on every request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- start_tid  in  `NOU_TID_WIDTH  transaction id copied onto every flit
- hdr_addr  in  ADDR_WIDTH  header base address, BPB-aligned
- hdr_sz  in  SZ_WIDTH  header length in bytes
- dat_addr  in  ADDR_WIDTH  data base address, BPB-aligned
- dat_sz  in  SZ_WIDTH  data length in bytes
- busy  out  1  high from accepted start until done
- rd_done  out  1  one-cycle pulse when the last flit completes its handshake
- rd_err  out  1  valid with rd_done; 1 if any beat returned RRESP != OKAY
- axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvld  out  AR channel
- axi_arrdy  in  1
- axi_rid  in  ID_WIDTH
- axi_rdata  in  DATA_WIDTH
- axi_rresp  in  2
- axi_rlast  in  1
- axi_rvld  in  1
- axi_rrdy  out  1
- od_valid  out  1  outbound flit valid
- od_dat_tid  out  `NOU_TID_WIDTH  latched start_tid
- od_dat_type  out  `NOU_TYPE_WIDTH  HDR_FLIT, DAT_FLIT, or *_LAST variant on the final flit
- od_dat_data  out  DATA_WIDTH  flit payload
- od_ready  in  1

Behaviour:
- Reset: all outputs 0. State IDLE. Flit register empty. Error flag cleared. Reset mid-transfer abandons the transfer with no done pulse; AXI slave-side cleanup is the system's responsibility.
- FSM: IDLE -> AR -> R -> (AR | DONE) -> IDLE.
  - IDLE: on start, latch tid, addresses and sizes; compute beats = (sz + BPB-1) / BPB per region. Region = HDR if hdr beats > 0, else DAT. If both regions are 0, go directly to DONE.
  - AR: arvld=1, araddr = current address, arlen = n-1 where n = min(remaining beats, MAX_BURST), arsize = log2(BPB), arburst = INCR. Hold stable until arrdy; then go to R.
  - R: axi_rrdy = !flit_full || od_ready. Each accepted beat loads the flit register and decrements the burst and region counters. On the beat with rlast, add n*BPB to the address.
  - After rlast: if region beats remain -> AR. Else if HDR and data beats > 0 -> switch to DAT and go to AR. Else -> DONE.
  - DONE: wait until the flit register has drained; pulse rd_done with rd_err; go to IDLE.
- Only one burst is outstanding at a time; no AR is issued until the previous rlast is accepted.
- Flit register is a one-entry pipeline stage:
  - od_valid stays held until od_ready.
  - Load and drain in the same cycle is allowed, giving full throughput.
  - Latency from R handshake to od_valid is 1 cycle.
- od_dat_type:
  - HDR_FLIT for header beats; *_LAST on the final header beat only when data size is 0.
  - DAT_FLIT for data beats; DAT_LAST on the final data beat.
- rlast mismatch: rlast before the count reaches 0, or the count reaching 0 without rlast, sets the error flag. The burst ends on whichever comes first.
- RRESP != 0 sets the sticky error flag. Flits are still forwarded.
- start while busy is ignored.
- The tail bytes of a final partial beat are passed through unmasked.

Optional Feature:
- NOU_SPU_4K_SPLIT_EN defined: n = min(remaining, MAX_BURST, (4096 - addr[11:0]) / BPB), so no burst crosses a 4 KB boundary.
- Not defined: n = min(remaining, MAX_BURST), and addresses are not checked.

Decomposition:
- nou_spu_pkg holds:
  - flit type codes (HDR_FLIT, HDR_LAST, DAT_FLIT, DAT_LAST);
  - the AXI burst/size/resp constants;
  - the region enum and FSM state enum.
- Sub-module nou_spu_burst_calc: combinational computation of n and arlen from address, remaining beats and MAX_BURST, including the 4 KB clamp. Keeps the FSM file lean.

Test Plan:
- hdr_sz=128, dat_sz=1024, od_ready=1 -> AR len=1 @hdr_addr, then AR len=15 @dat_addr; 2 HDR_FLIT then 16 DAT flits, the last typed DAT_LAST; rd_done once, rd_err=0.
- dat_sz=64*40, MAX_BURST=16 -> arlen sequence 15, 15, 7; addresses advance by 1024, 1024; 40 flits in order.
- od_ready toggled randomly, 50% duty -> no flit lost or duplicated; rrdy low whenever the flit register is full and od_ready=0; data matches the memory model.
- One beat returns RRESP=2 -> all flits still delivered; rd_done pulses with rd_err=1; next packet reports rd_err=0.
- hdr_sz=0, dat_sz=0 -> no AR issued; rd_done pulses 2 cycles after start.
- NOU_SPU_4K_SPLIT_EN, dat_addr=0x0F80, dat_sz=512 -> bursts len=1 @0x0F80 then len=5 @0x1000; without the macro, a single len=7 burst.

Source files
------------

// File: rtl/nou_spu_pkg.sv
// nou_spu_pkg: shared constants and types for the NOU send-side read master.
//   - flit type codes placed on od_dat_type
//   - AXI burst / resp encodings
//   - FSM state codes and the region enum
// The TID/TYPE widths come from system-wide macros. Fallback values are
// supplied here so that the slice builds on its own.

`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 2
`endif

package nou_spu_pkg;

  localparam int TID_W  = `NOU_TID_WIDTH;
  localparam int TYPE_W = `NOU_TYPE_WIDTH;

  // outbound flit type codes
  localparam logic [TYPE_W-1:0] HDR_FLIT = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] HDR_LAST = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] DAT_FLIT = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] DAT_LAST = TYPE_W'(3);

  // AXI encodings
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // packet region currently being fetched
  typedef enum logic {
    RGN_HDR = 1'b0,
    RGN_DAT = 1'b1
  } region_e;

endpackage

// File: rtl/nou_spu_burst_calc.sv
// nou_spu_burst_calc: combinational burst sizing for the read master.
//   page_off   in  low 12 address bits of the next burst
//   remaining  in  beats still to fetch in the current region
//   n          out beats in the next burst
//   arlen      out n-1, in AXI encoding
// n = min(remaining, MAX_BURST). With NOU_SPU_4K_SPLIT_EN defined, n is also
// clamped so that the burst stops at the next 4 KB boundary.

module nou_spu_burst_calc
  import nou_spu_pkg::*;
#(
  parameter int SZ_WIDTH  = 16,
  parameter int BPB       = 64,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]         page_off,
  input  logic [SZ_WIDTH-1:0] remaining,
  output logic [8:0]          n,
  output logic [7:0]          arlen
);

  localparam int BPB_LOG2 = $clog2(BPB);
  // compare width covering both the beat counter and the 13-bit page math
  localparam int CW = (SZ_WIDTH > 13) ? SZ_WIDTH : 13;

  logic [CW-1:0] rem_c;
  logic [CW-1:0] lim_c;

`ifdef NOU_SPU_4K_SPLIT_EN
  logic [12:0] page_bytes;
  logic [12:0] page_beats;

  always_comb begin
    // a BPB-aligned address always leaves at least one whole beat in the page
    page_bytes = 13'h1000 - {1'b0, page_off};
    page_beats = page_bytes >> BPB_LOG2;
    lim_c      = CW'(MAX_BURST);
    if (CW'(page_beats) < lim_c) begin
      lim_c = CW'(page_beats);
    end
  end
`else
  logic unused_page_off;
  assign unused_page_off = ^page_off;

  always_comb begin
    lim_c = CW'(MAX_BURST);
  end
`endif

  assign rem_c = CW'(remaining);
  assign n     = 9'((rem_c < lim_c) ? rem_c : lim_c);
  assign arlen = 8'(n - 9'd1);

endmodule

// File: rtl/nou_spu_rd_master.sv
// nou_spu_rd_master: fetches a packet (header region, then data region) over
// AXI read and emits it as data flits towards the router.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start/start_tid          one-cycle request and transaction id
//   hdr_addr/hdr_sz          header base (BPB-aligned) and length in bytes
//   dat_addr/dat_sz          data base (BPB-aligned) and length in bytes
//   busy, rd_done, rd_err    status; rd_err qualifies the rd_done pulse
//   axi_ar*                  AXI read address channel (master)
//   axi_r*                   AXI read data channel (master)
//   od_*                     outbound data flit channel, valid/ready
//
// Build option: NOU_SPU_4K_SPLIT_EN keeps every burst inside one 4 KB page.
//
// state   | meaning
// IDLE    | waiting for start
// AR      | presenting one burst request, held until arrdy
// R       | accepting beats of the outstanding burst into the flit register
// DONE    | waiting for the last flit to leave, then pulse rd_done

module nou_spu_rd_master
  import nou_spu_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int SZ_WIDTH   = 16,
  parameter int MAX_BURST  = 16,
  parameter int ARID_VAL   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [`NOU_TID_WIDTH-1:0]  start_tid,
  input  logic [ADDR_WIDTH-1:0]      hdr_addr,
  input  logic [SZ_WIDTH-1:0]        hdr_sz,
  input  logic [ADDR_WIDTH-1:0]      dat_addr,
  input  logic [SZ_WIDTH-1:0]        dat_sz,
  output logic                       busy,
  output logic                       rd_done,
  output logic                       rd_err,
  output logic [ID_WIDTH-1:0]        axi_arid,
  output logic [ADDR_WIDTH-1:0]      axi_araddr,
  output logic [7:0]                 axi_arlen,
  output logic [2:0]                 axi_arsize,
  output logic [1:0]                 axi_arburst,
  output logic                       axi_arvld,
  input  logic                       axi_arrdy,
  input  logic [ID_WIDTH-1:0]        axi_rid,
  input  logic [DATA_WIDTH-1:0]      axi_rdata,
  input  logic [1:0]                 axi_rresp,
  input  logic                       axi_rlast,
  input  logic                       axi_rvld,
  output logic                       axi_rrdy,
  output logic                       od_valid,
  output logic [`NOU_TID_WIDTH-1:0]  od_dat_tid,
  output logic [`NOU_TYPE_WIDTH-1:0] od_dat_type,
  output logic [DATA_WIDTH-1:0]      od_dat_data,
  input  logic                       od_ready
);

  localparam int BPB      = DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam int SZP1     = SZ_WIDTH + 1;

  logic [1:0]                state;
  region_e                   region;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [ADDR_WIDTH-1:0]     dat_addr_q;
  logic [SZ_WIDTH-1:0]       region_left;
  logic [SZ_WIDTH-1:0]       dat_beats;
  logic [8:0]                burst_n;
  logic [8:0]                burst_left;
  logic                      err;
  logic                      flit_full;
  logic [`NOU_TID_WIDTH-1:0] tid_q;

  logic [SZ_WIDTH:0]         hdr_round;
  logic [SZ_WIDTH:0]         dat_round;
  logic [SZ_WIDTH-1:0]       hdr_beats_in;
  logic [SZ_WIDTH-1:0]       dat_beats_in;
  logic [8:0]                calc_n;
  logic [7:0]                calc_arlen;
  logic                      ar_active;
  logic                      rd_hs;
  logic                      cnt_last;
  logic                      burst_end;
  logic [SZ_WIDTH-1:0]       region_left_dec;
  logic [`NOU_TYPE_WIDTH-1:0] beat_type;

  logic unused_rid;
  assign unused_rid = ^axi_rid;

  // byte size -> beat count, rounding a partial tail beat up
  assign hdr_round    = {1'b0, hdr_sz} + SZP1'(BPB - 1);
  assign dat_round    = {1'b0, dat_sz} + SZP1'(BPB - 1);
  assign hdr_beats_in = SZ_WIDTH'(hdr_round >> BPB_LOG2);
  assign dat_beats_in = SZ_WIDTH'(dat_round >> BPB_LOG2);

  nou_spu_burst_calc #(
    .SZ_WIDTH  (SZ_WIDTH),
    .BPB       (BPB),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .page_off  (cur_addr[11:0]),
    .remaining (region_left),
    .n         (calc_n),
    .arlen     (calc_arlen)
  );

  assign ar_active   = (state == ST_AR);
  assign axi_arvld   = ar_active;
  assign axi_araddr  = ar_active ? cur_addr : '0;
  assign axi_arlen   = ar_active ? calc_arlen : 8'd0;
  assign axi_arsize  = ar_active ? 3'(BPB_LOG2) : 3'd0;
  assign axi_arburst = ar_active ? AXI_BURST_INCR : 2'b00;
  assign axi_arid    = ar_active ? ID_WIDTH'(ARID_VAL) : '0;

  assign busy      = (state != ST_IDLE);
  assign axi_rrdy  = (state == ST_R) && (!flit_full || od_ready);
  assign rd_hs     = axi_rvld && axi_rrdy;
  assign cnt_last  = (burst_left == 9'd1);
  // a burst ends on rlast or on the expected count, whichever comes first
  assign burst_end = axi_rlast || cnt_last;
  assign region_left_dec = region_left - SZ_WIDTH'(1);

  always_comb begin
    if (region == RGN_HDR) begin
      beat_type = ((region_left == SZ_WIDTH'(1)) && (dat_beats == '0)) ? HDR_LAST : HDR_FLIT;
    end else begin
      beat_type = (region_left == SZ_WIDTH'(1)) ? DAT_LAST : DAT_FLIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      region      <= RGN_HDR;
      cur_addr    <= '0;
      dat_addr_q  <= '0;
      region_left <= '0;
      dat_beats   <= '0;
      burst_n     <= '0;
      burst_left  <= '0;
      err         <= 1'b0;
      tid_q       <= '0;
      rd_done     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tid_q      <= start_tid;
            dat_addr_q <= dat_addr;
            dat_beats  <= dat_beats_in;
            err        <= 1'b0;
            if (hdr_beats_in != '0) begin
              region      <= RGN_HDR;
              cur_addr    <= hdr_addr;
              region_left <= hdr_beats_in;
              state       <= ST_AR;
            end else if (dat_beats_in != '0) begin
              region      <= RGN_DAT;
              cur_addr    <= dat_addr;
              region_left <= dat_beats_in;
              state       <= ST_AR;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_AR: begin
          if (axi_arrdy) begin
            burst_n    <= calc_n;
            burst_left <= calc_n;
            state      <= ST_R;
          end
        end
        ST_R: begin
          if (rd_hs) begin
            burst_left  <= burst_left - 9'd1;
            region_left <= region_left_dec;
            if ((axi_rresp != AXI_RESP_OKAY) || (axi_rlast != cnt_last)) begin
              err <= 1'b1;
            end
            if (burst_end) begin
              cur_addr <= cur_addr + (ADDR_WIDTH'(burst_n) << BPB_LOG2);
              if (region_left_dec != '0) begin
                state <= ST_AR;
              end else if ((region == RGN_HDR) && (dat_beats != '0)) begin
                region      <= RGN_DAT;
                cur_addr    <= dat_addr_q;
                region_left <= dat_beats;
                state       <= ST_AR;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          // the flit leaving this cycle (if any) is the last one
          if (!flit_full || od_ready) begin
            rd_done <= 1'b1;
            rd_err  <= err;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // one-entry flit stage; load and drain in one cycle keeps full throughput
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_full   <= 1'b0;
      od_dat_tid  <= '0;
      od_dat_type <= '0;
      od_dat_data <= '0;
    end else if (rd_hs) begin
      flit_full   <= 1'b1;
      od_dat_tid  <= tid_q;
      od_dat_type <= beat_type;
      od_dat_data <= axi_rdata;
    end else if (od_ready) begin
      flit_full <= 1'b0;
    end
  end

  assign od_valid = flit_full;

endmodule

// File: tb/tb_nou_spu_rd_master.sv
`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 2
`endif

module tb_nou_spu_rd_master;
  import nou_spu_pkg::*;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int SW = 16;

  logic                       clk;
  logic                       rst;
  logic                       start;
  logic [`NOU_TID_WIDTH-1:0]  start_tid;
  logic [AW-1:0]              hdr_addr;
  logic [SW-1:0]              hdr_sz;
  logic [AW-1:0]              dat_addr;
  logic [SW-1:0]              dat_sz;
  logic                       busy;
  logic                       rd_done;
  logic                       rd_err;
  logic [IW-1:0]              axi_arid;
  logic [AW-1:0]              axi_araddr;
  logic [7:0]                 axi_arlen;
  logic [2:0]                 axi_arsize;
  logic [1:0]                 axi_arburst;
  logic                       axi_arvld;
  logic                       axi_arrdy;
  logic [IW-1:0]              axi_rid;
  logic [DW-1:0]              axi_rdata;
  logic [1:0]                 axi_rresp;
  logic                       axi_rlast;
  logic                       axi_rvld;
  logic                       axi_rrdy;
  logic                       od_valid;
  logic [`NOU_TID_WIDTH-1:0]  od_dat_tid;
  logic [`NOU_TYPE_WIDTH-1:0] od_dat_type;
  logic [DW-1:0]              od_dat_data;
  logic                       od_ready;

  nou_spu_rd_master dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_tid   (start_tid),
    .hdr_addr    (hdr_addr),
    .hdr_sz      (hdr_sz),
    .dat_addr    (dat_addr),
    .dat_sz      (dat_sz),
    .busy        (busy),
    .rd_done     (rd_done),
    .rd_err      (rd_err),
    .axi_arid    (axi_arid),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvld   (axi_arvld),
    .axi_arrdy   (axi_arrdy),
    .axi_rid     (axi_rid),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvld    (axi_rvld),
    .axi_rrdy    (axi_rrdy),
    .od_valid    (od_valid),
    .od_dat_tid  (od_dat_tid),
    .od_dat_type (od_dat_type),
    .od_dat_data (od_dat_data),
    .od_ready    (od_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model: every beat carries its own byte address replicated
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{a}};
  endfunction

  // recorded AR requests, accepted flits, done pulses
  logic [AW-1:0] ar_addr_q[$];
  logic [7:0]    ar_len_q[$];
  logic [2:0]    ar_size_q[$];
  logic [DW-1:0] fl_data_q[$];
  logic [1:0]    fl_type_q[$];
  logic [7:0]    fl_tid_q[$];
  int  beat_total = 0;
  int  err_beat   = -1;
  int  done_cnt   = 0;
  int  rrdy_viol  = 0;
  logic last_err  = 1'b0;
  bit  rnd_ready  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI read slave: one burst at a time, all inputs driven on the falling edge
  initial begin : slave
    logic [AW-1:0] a;
    logic [7:0]    l;
    logic          hs;
    axi_arrdy = 1'b0;
    axi_rvld  = 1'b0;
    axi_rdata = '0;
    axi_rresp = 2'b00;
    axi_rlast = 1'b0;
    axi_rid   = '0;
    forever begin
      @(negedge clk);
      axi_rvld  = 1'b0;
      axi_rlast = 1'b0;
      axi_rresp = 2'b00;
      if (axi_arvld && !rst) begin
        a = axi_araddr;
        l = axi_arlen;
        ar_addr_q.push_back(a);
        ar_len_q.push_back(l);
        ar_size_q.push_back(axi_arsize);
        axi_arrdy = 1'b1;
        @(negedge clk);
        axi_arrdy = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
          axi_rvld  = 1'b1;
          axi_rdata = pat(a + 64'(i) * 64);
          axi_rlast = (i == int'(l));
          axi_rresp = (beat_total == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          hs = 1'b0;
          while (!hs) begin
            #4;
            hs = axi_rrdy;
            @(negedge clk);
          end
          beat_total++;
        end
        axi_rvld  = 1'b0;
        axi_rlast = 1'b0;
        axi_rresp = 2'b00;
      end
    end
  end

  // flit sink and done monitor, sampled 1 time unit before the rising edge
  initial begin : mon
    od_ready = 1'b1;
    forever begin
      @(negedge clk);
      od_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (od_valid && od_ready) begin
        fl_data_q.push_back(od_dat_data);
        fl_type_q.push_back(od_dat_type);
        fl_tid_q.push_back(od_dat_tid);
      end
      if (od_valid && !od_ready && axi_rrdy) rrdy_viol++;
      if (rd_done) begin
        done_cnt++;
        last_err = rd_err;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] tid, input logic [AW-1:0] ha, input logic [SW-1:0] hs,
                      input logic [AW-1:0] da, input logic [SW-1:0] ds);
    @(negedge clk);
    start     = 1'b1;
    start_tid = tid;
    hdr_addr  = ha;
    hdr_sz    = hs;
    dat_addr  = da;
    dat_sz    = ds;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n;
    n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #5;
    chk(tag, DW'(done_cnt), DW'(prev + 1));
  endtask

  task automatic chk_ar(input int idx, input logic [AW-1:0] addr, input logic [7:0] len);
    if (idx < ar_addr_q.size()) begin
      chk("ar_addr", DW'(ar_addr_q[idx]), DW'(addr));
      chk("ar_len", DW'(ar_len_q[idx]), DW'(len));
      chk("ar_size", DW'(ar_size_q[idx]), DW'(3'd6));
    end else begin
      chk("ar_missing", DW'(ar_addr_q.size()), DW'(idx + 1));
    end
  endtask

  task automatic chk_flits(input int base, input logic [7:0] tid, input logic [AW-1:0] ha, input int hb,
                           input logic [AW-1:0] da, input int db);
    logic [AW-1:0] a;
    logic [1:0]    t;
    chk("flit_count", DW'(fl_data_q.size() - base), DW'(hb + db));
    for (int k = 0; k < hb + db && base + k < fl_data_q.size(); k++) begin
      if (k < hb) begin
        a = ha + 64'(k) * 64;
        t = (k == hb - 1 && db == 0) ? HDR_LAST : HDR_FLIT;
      end else begin
        a = da + 64'(k - hb) * 64;
        t = (k == hb + db - 1) ? DAT_LAST : DAT_FLIT;
      end
      chk("flit_data", fl_data_q[base + k], pat(a));
      chk("flit_type", DW'(fl_type_q[base + k]), DW'(t));
      chk("flit_tid", DW'(fl_tid_q[base + k]), DW'(tid));
    end
  endtask

  initial begin : main
    int ab, fb, d;
    rst       = 1'b1;
    start     = 1'b0;
    start_tid = '0;
    hdr_addr  = '0;
    hdr_sz    = '0;
    dat_addr  = '0;
    dat_sz    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", DW'(busy), DW'(1'b0));
    chk("rst_done", DW'(rd_done), DW'(1'b0));
    chk("rst_err", DW'(rd_err), DW'(1'b0));
    chk("rst_arvld", DW'(axi_arvld), DW'(1'b0));
    chk("rst_araddr", DW'(axi_araddr), DW'(0));
    chk("rst_rrdy", DW'(axi_rrdy), DW'(1'b0));
    chk("rst_od_valid", DW'(od_valid), DW'(1'b0));
    chk("rst_od_data", od_dat_data, DW'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // header 2 beats, data 16 beats
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt;
    send(8'h11, 64'h1000, 16'd128, 64'h2000, 16'd1024);
    wait_done(d, "t1_done");
    chk("t1_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(2));
    chk_ar(ab, 64'h1000, 8'd1);
    chk_ar(ab + 1, 64'h2000, 8'd15);
    chk_flits(fb, 8'h11, 64'h1000, 2, 64'h2000, 16);
    chk("t1_err", DW'(last_err), DW'(1'b0));

    // data only, 40 beats split 16/16/8
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt;
    send(8'h22, 64'h0, 16'd0, 64'h10000, 16'd2560);
    wait_done(d, "t2_done");
    chk("t2_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(3));
    chk_ar(ab, 64'h10000, 8'd15);
    chk_ar(ab + 1, 64'h10400, 8'd15);
    chk_ar(ab + 2, 64'h10800, 8'd7);
    chk_flits(fb, 8'h22, 64'h0, 0, 64'h10000, 40);

    // random backpressure, partial beats, a start while busy is ignored
    rnd_ready = 1'b1;
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt; rrdy_viol = 0;
    send(8'h33, 64'h3000, 16'd100, 64'h5000, 16'd3000);
    repeat (5) @(negedge clk);
    #1;
    chk("t3_busy", DW'(busy), DW'(1'b1));
    send(8'h44, 64'h9000, 16'd64, 64'hA000, 16'd64);
    wait_done(d, "t3_done");
    rnd_ready = 1'b0;
    chk("t3_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(4));
    chk_ar(ab, 64'h3000, 8'd1);
    chk_ar(ab + 1, 64'h5000, 8'd15);
    chk_ar(ab + 2, 64'h5400, 8'd15);
    chk_ar(ab + 3, 64'h5800, 8'd14);
    chk_flits(fb, 8'h33, 64'h3000, 2, 64'h5000, 47);
    chk("t3_rrdy_viol", DW'(rrdy_viol), DW'(0));
    chk("t3_err", DW'(last_err), DW'(1'b0));

    // SLVERR on the fourth beat: flits still delivered, rd_err reported
    fb = fl_data_q.size(); d = done_cnt;
    err_beat = beat_total + 3;
    send(8'h55, 64'h6000, 16'd64, 64'h7000, 16'd256);
    wait_done(d, "t4_done");
    chk_flits(fb, 8'h55, 64'h6000, 1, 64'h7000, 4);
    chk("t4_err", DW'(last_err), DW'(1'b1));

    // next packet is clean again; header-only gives HDR_LAST
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt;
    send(8'h66, 64'h8000, 16'd64, 64'h9000, 16'd0);
    wait_done(d, "t5_done");
    chk_ar(ab, 64'h8000, 8'd0);
    chk_flits(fb, 8'h66, 64'h8000, 1, 64'h9000, 0);
    chk("t5_err", DW'(last_err), DW'(1'b0));

    // empty packet: no AR, rd_done two cycles after start
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt;
    @(negedge clk);
    start = 1'b1; start_tid = 8'h5A; hdr_sz = 16'd0; dat_sz = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("t6_busy_c1", DW'(busy), DW'(1'b1));
    chk("t6_done_c1", DW'(rd_done), DW'(1'b0));
    @(negedge clk);
    #1;
    chk("t6_done_c2", DW'(rd_done), DW'(1'b1));
    chk("t6_err_c2", DW'(rd_err), DW'(1'b0));
    chk("t6_busy_c2", DW'(busy), DW'(1'b0));
    repeat (4) @(negedge clk);
    chk("t6_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(0));
    chk("t6_flit_cnt", DW'(fl_data_q.size() - fb), DW'(0));
    chk("t6_done_cnt", DW'(done_cnt), DW'(d + 1));

    // burst starting 128 bytes below a 4 KB boundary
    ab = ar_addr_q.size(); fb = fl_data_q.size(); d = done_cnt;
    send(8'h77, 64'h0, 16'd0, 64'h0F80, 16'd512);
    wait_done(d, "t7_done");
`ifdef NOU_SPU_4K_SPLIT_EN
    chk("t7_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(2));
    chk_ar(ab, 64'h0F80, 8'd1);
    chk_ar(ab + 1, 64'h1000, 8'd5);
`else
    chk("t7_ar_cnt", DW'(ar_addr_q.size() - ab), DW'(1));
    chk_ar(ab, 64'h0F80, 8'd7);
`endif
    chk_flits(fb, 8'h77, 64'h0, 0, 64'h0F80, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
